// File: rtl/sd_init_sequencer_pkg.sv
// Shared constants, state/command-select enums and command decode helpers for the
// SD card identification sequencer.
package sd_init_sequencer_pkg;

    localparam logic RSP_TYPE_SHORT = 1'b0;
    localparam logic RSP_TYPE_LONG  = 1'b1;

    localparam logic [5:0] CMD_GO_IDLE          = 6'd0;
    localparam logic [5:0] CMD_ALL_SEND_CID     = 6'd2;
    localparam logic [5:0] CMD_SEND_RCA         = 6'd3;
    localparam logic [5:0] CMD_SEND_IF_COND     = 6'd8;
    localparam logic [5:0] ACMD_SD_SEND_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP_CMD          = 6'd55;

    localparam logic [7:0] ERR_NONE         = 8'h00;
    localparam logic [7:0] ERR_NO_CARD      = 8'h01;
    localparam logic [7:0] ERR_CMD_TIMEOUT  = 8'h02;
    localparam logic [7:0] ERR_VOLTAGE      = 8'h03;
    localparam logic [7:0] ERR_INIT_TIMEOUT = 8'h04;

    localparam logic [31:0] CMD8_ARG = 32'h0000_01AA;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT_RSP, ST_EVAL, ST_GAP, ST_DONE, ST_ERROR
    } state_e;

    typedef enum logic [2:0] {
        SEL_CMD0, SEL_CMD8, SEL_CMD55, SEL_ACMD41, SEL_CMD2, SEL_CMD3
    } cmd_sel_e;

    function automatic logic [5:0] cmd_index(input cmd_sel_e sel);
        case (sel)
            SEL_CMD8:   return CMD_SEND_IF_COND;
            SEL_CMD55:  return CMD_APP_CMD;
            SEL_ACMD41: return ACMD_SD_SEND_OP_COND;
            SEL_CMD2:   return CMD_ALL_SEND_CID;
            SEL_CMD3:   return CMD_SEND_RCA;
            default:    return CMD_GO_IDLE;
        endcase
    endfunction

    // HCS is only requested from cards that proved v2 support via CMD8.
    function automatic logic [31:0] cmd_arg(input cmd_sel_e sel, input logic v2);
        case (sel)
            SEL_CMD8:   return CMD8_ARG;
            SEL_ACMD41: return {1'b0, v2, 6'b0, 24'hFF8000};
            default:    return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/sd_init_sequencer_cmd_timer.sv
// Loadable 16-bit saturating cycle timer; o_expire flags the cycle the count
// reaches i_limit-1 while enabled.
module sd_cmd_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_enable,
    input  logic [15:0] i_limit,
    output logic [15:0] o_count,
    output logic        o_expire
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load)
            count_d = i_load_val;
        else if (i_enable && (count_q != 16'hFFFF))
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign o_count  = count_q;
    assign o_expire = i_enable && !i_load && (count_q == (i_limit - 16'd1));

endmodule

// File: rtl/sd_init_sequencer.sv
// SD card identification sequencer: CMD0, CMD8, (CMD55+ACMD41)*, CMD2, CMD3.
// Define SD_INIT_CID_CAPTURE_EN to add the o_cid port holding the CMD2 response.
module sd_init_sequencer
    import sd_init_sequencer_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [9:0]  ACMD41_RETRIES = 10'd1000,
    parameter logic [7:0]  GAP_CYCLES     = 8'd8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_card_detect,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_error_flag,
    output logic [7:0]   o_error,
    output logic         o_ccs,
    output logic         o_v2_card,
    output logic [31:0]  o_ocr,
    output logic [15:0]  o_rca,
    output logic         o_cmd_en,
    output logic [5:0]   o_cmd,
    output logic [31:0]  o_cmd_arg,
    output logic         o_rsp_type,
    input  logic         i_cmd_finished_en,
    input  logic [7:0]   i_cmd_error,
    input  logic [127:0] i_rsp
`ifdef SD_INIT_CID_CAPTURE_EN
    ,
    output logic [127:0] o_cid
`endif
);

    state_e      state_q, state_d;
    cmd_sel_e    sel_q, sel_d;
    logic        cmd_en_q, cmd_en_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic        rsp_type_q, rsp_type_d;
    logic        v2_q, v2_d;
    logic        ccs_q, ccs_d;
    logic [31:0] ocr_q, ocr_d;
    logic [15:0] rca_q, rca_d;
    logic [7:0]  error_q, error_d;
    logic [31:0] payload_q, payload_d;
    logic [7:0]  rsp_err_q, rsp_err_d;
    logic        timeout_q, timeout_d;
    logic [9:0]  retry_q, retry_d;
    logic [9:0]  retry_next;
    logic [7:0]  gap_q, gap_d;
`ifdef SD_INIT_CID_CAPTURE_EN
    logic [127:0] cid_q, cid_d;
`endif

    logic        busy;
    logic        timer_load;
    logic        timer_expire;
    logic [15:0] timer_count;
    logic        unused_bits;

    sd_cmd_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (timer_load),
        .i_load_val (16'd0),
        .i_enable   (state_q == ST_WAIT_RSP),
        .i_limit    (TIMEOUT_CYCLES),
        .o_count    (timer_count),
        .o_expire   (timer_expire)
    );

    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RSP) ||
                         (state_q == ST_EVAL)  || (state_q == ST_GAP);
    assign retry_next  = (retry_q == 10'h3FF) ? retry_q : retry_q + 10'd1;
    assign unused_bits = ^{i_rsp[127:32], timer_count};

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cmd_en_d   = cmd_en_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        rsp_type_d = rsp_type_q;
        v2_d       = v2_q;
        ccs_d      = ccs_q;
        ocr_d      = ocr_q;
        rca_d      = rca_q;
        error_d    = error_q;
        payload_d  = payload_q;
        rsp_err_d  = rsp_err_q;
        timeout_d  = timeout_q;
        retry_d    = retry_q;
        gap_d      = gap_q;
        timer_load = 1'b0;
`ifdef SD_INIT_CID_CAPTURE_EN
        cid_d      = cid_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start && i_card_detect) begin
                    v2_d    = 1'b0;
                    ccs_d   = 1'b0;
                    ocr_d   = '0;
                    rca_d   = '0;
                    error_d = ERR_NONE;
                    retry_d = '0;
                    sel_d   = SEL_CMD0;
                    state_d = ST_ISSUE;
`ifdef SD_INIT_CID_CAPTURE_EN
                    cid_d   = '0;
`endif
                end
            end
            ST_ISSUE: begin
                cmd_d      = cmd_index(sel_q);
                arg_d      = cmd_arg(sel_q, v2_q);
                rsp_type_d = (sel_q == SEL_CMD2) ? RSP_TYPE_LONG : RSP_TYPE_SHORT;
                cmd_en_d   = 1'b1;
                timer_load = 1'b1;
                state_d    = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (i_cmd_finished_en) begin
                    payload_d = i_rsp[31:0];
                    rsp_err_d = i_cmd_error;
                    timeout_d = 1'b0;
                    cmd_en_d  = 1'b0;
                    state_d   = ST_EVAL;
`ifdef SD_INIT_CID_CAPTURE_EN
                    if (sel_q == SEL_CMD2) cid_d = i_rsp;
`endif
                end else if (timer_expire) begin
                    rsp_err_d = ERR_NONE;
                    timeout_d = 1'b1;
                    cmd_en_d  = 1'b0;
                    state_d   = ST_EVAL;
                end
            end
            ST_EVAL: begin
                gap_d   = '0;
                state_d = ST_GAP;
                // CMD0 has no response worth judging; anything moves on to CMD8.
                if (sel_q == SEL_CMD0) begin
                    sel_d = SEL_CMD8;
                end else if (rsp_err_q != ERR_NONE) begin
                    error_d = rsp_err_q;
                    state_d = ST_ERROR;
                end else if (timeout_q) begin
                    if (sel_q == SEL_CMD8) begin
                        v2_d  = 1'b0;
                        sel_d = SEL_CMD55;
                    end else begin
                        error_d = ERR_CMD_TIMEOUT;
                        state_d = ST_ERROR;
                    end
                end else begin
                    case (sel_q)
                        SEL_CMD8: begin
                            if (payload_q[11:0] == 12'h1AA) begin
                                v2_d  = 1'b1;
                                sel_d = SEL_CMD55;
                            end else begin
                                error_d = ERR_VOLTAGE;
                                state_d = ST_ERROR;
                            end
                        end
                        SEL_CMD55: sel_d = SEL_ACMD41;
                        SEL_ACMD41: begin
                            ocr_d = payload_q;
                            if (payload_q[31]) begin
                                ccs_d = payload_q[30] & v2_q;
                                sel_d = SEL_CMD2;
                            end else begin
                                retry_d = retry_next;
                                if (retry_next >= ACMD41_RETRIES) begin
                                    error_d = ERR_INIT_TIMEOUT;
                                    state_d = ST_ERROR;
                                end else begin
                                    sel_d = SEL_CMD55;
                                end
                            end
                        end
                        SEL_CMD2: sel_d = SEL_CMD3;
                        SEL_CMD3: begin
                            rca_d   = payload_q[31:16];
                            state_d = ST_DONE;
                        end
                        default: sel_d = SEL_CMD0;
                    endcase
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 8'd1;
                if (gap_q >= (GAP_CYCLES - 8'd1)) state_d = ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Card removal outranks everything, including a completion in the same cycle.
        if (busy && !i_card_detect) begin
            cmd_en_d = 1'b0;
            error_d  = ERR_NO_CARD;
            state_d  = ST_ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_CMD0;
            cmd_en_q   <= 1'b0;
            cmd_q      <= '0;
            arg_q      <= '0;
            rsp_type_q <= RSP_TYPE_SHORT;
            v2_q       <= 1'b0;
            ccs_q      <= 1'b0;
            ocr_q      <= '0;
            rca_q      <= '0;
            error_q    <= ERR_NONE;
            payload_q  <= '0;
            rsp_err_q  <= ERR_NONE;
            timeout_q  <= 1'b0;
            retry_q    <= '0;
            gap_q      <= '0;
`ifdef SD_INIT_CID_CAPTURE_EN
            cid_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cmd_en_q   <= cmd_en_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            rsp_type_q <= rsp_type_d;
            v2_q       <= v2_d;
            ccs_q      <= ccs_d;
            ocr_q      <= ocr_d;
            rca_q      <= rca_d;
            error_q    <= error_d;
            payload_q  <= payload_d;
            rsp_err_q  <= rsp_err_d;
            timeout_q  <= timeout_d;
            retry_q    <= retry_d;
            gap_q      <= gap_d;
`ifdef SD_INIT_CID_CAPTURE_EN
            cid_q      <= cid_d;
`endif
        end
    end

    assign o_busy       = busy;
    assign o_done       = (state_q == ST_DONE);
    assign o_error_flag = (state_q == ST_ERROR);
    assign o_error      = error_q;
    assign o_ccs        = ccs_q;
    assign o_v2_card    = v2_q;
    assign o_ocr        = ocr_q;
    assign o_rca        = rca_q;
    assign o_cmd_en     = cmd_en_q;
    assign o_cmd        = cmd_q;
    assign o_cmd_arg    = arg_q;
    assign o_rsp_type   = rsp_type_q;
`ifdef SD_INIT_CID_CAPTURE_EN
    assign o_cid        = cid_q;
`endif

endmodule
